// File: rtl/config_interface.sv
// config_interface: UART-framed configuration register file with read-back.
// Build option CONFIG_INTERFACE_WRITE_ECHO_EN echoes every accepted write.
module config_interface #(
  parameter int NUMREGS      = 16,
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              posi,
  output logic              piso,
  output logic [DATA_W-1:0] config_bits [0:NUMREGS-1],
  output logic [7:0]        err_count,
  output logic              rx_busy,
  output logic              tx_busy
);
  localparam int N  = ADDR_W + DATA_W + 4;
  localparam int SW = N - 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(N);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BITS_ONE = BW'(1);
  localparam logic [BW-1:0] RX_LAST  = BW'(SW - 1);
  localparam logic [BW-1:0] TX_LAST  = BW'(N - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic              sync1;
  logic              sync2;
  logic [1:0]        state;
  logic [CW-1:0]     rx_cnt;
  logic [BW-1:0]     rx_bits;
  logic [SW-1:0]     rx_sr;
  logic              eval;
  logic              stop_bit;

  logic              rx_wrb;
  logic [DATA_W-1:0] rx_data;
  logic [ADDR_W-1:0] rx_addr;
  logic              frame_ok;
  logic              wr_req;
  logic              resp_req;
  logic              load;
  logic              err_inc;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] resp_data;
  logic [N-1:0]      resp_frame;

  logic [N-1:0]      tx_sr;
  logic [CW-1:0]     tx_cnt;
  logic [BW-1:0]     tx_bits;

  assign rx_busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      state    <= S_IDLE;
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_sr    <= '0;
      eval     <= 1'b0;
      stop_bit <= 1'b0;
    end else begin
      sync1 <= posi;
      sync2 <= sync1;
      eval  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (!sync2) begin
            state  <= S_START;
            rx_cnt <= '0;
          end
        end
        S_START: begin
          if (rx_cnt == HALF_END) begin
            rx_cnt  <= '0;
            rx_bits <= '0;
            state   <= sync2 ? S_IDLE : S_DATA;
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        S_DATA: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt  <= '0;
            rx_sr   <= {sync2, rx_sr[SW-1:1]};
            rx_bits <= rx_bits + BITS_ONE;
            if (rx_bits == RX_LAST) state <= S_STOP;
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        S_STOP: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt   <= '0;
            stop_bit <= sync2;
            eval     <= 1'b1;
            state    <= S_IDLE;
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // rx_sr holds wrb, data, addr, parity with wrb at bit 0
  assign rx_wrb   = rx_sr[0];
  assign rx_data  = rx_sr[DATA_W:1];
  assign rx_addr  = rx_sr[DATA_W+ADDR_W:DATA_W+1];
  assign frame_ok = eval && stop_bit && !(^rx_sr);
  assign wr_req   = frame_ok && !rx_wrb;

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUMREGS; i++)
      if (rx_addr == ADDR_W'(i)) rd_data = config_bits[i];
  end

`ifdef CONFIG_INTERFACE_WRITE_ECHO_EN
  logic in_range;

  always_comb begin
    in_range = 1'b0;
    for (int i = 0; i < NUMREGS; i++)
      if (rx_addr == ADDR_W'(i)) in_range = 1'b1;
  end

  assign resp_req  = frame_ok;
  assign resp_data = rx_wrb ? rd_data : (in_range ? rx_data : '0);
`else
  assign resp_req  = frame_ok && rx_wrb;
  assign resp_data = rd_data;
`endif

  assign load       = resp_req && !tx_busy;
  assign err_inc    = (eval && !frame_ok) || (resp_req && tx_busy);
  assign resp_frame = {1'b1, ^{rx_addr, resp_data, rx_wrb},
                       rx_addr, resp_data, rx_wrb, 1'b0};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUMREGS; i++) config_bits[i] <= '0;
      err_count <= 8'd0;
    end else begin
      if (wr_req)
        for (int i = 0; i < NUMREGS; i++)
          if (rx_addr == ADDR_W'(i)) config_bits[i] <= rx_data;
      if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  // idle shifter is all ones so piso rests high
  assign piso = tx_sr[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_sr   <= '1;
      tx_cnt  <= '0;
      tx_bits <= '0;
      tx_busy <= 1'b0;
    end else if (load) begin
      tx_sr   <= resp_frame;
      tx_cnt  <= '0;
      tx_bits <= '0;
      tx_busy <= 1'b1;
    end else if (tx_busy) begin
      if (tx_cnt == BIT_END) begin
        tx_cnt  <= '0;
        tx_sr   <= {1'b1, tx_sr[N-1:1]};
        tx_bits <= tx_bits + BITS_ONE;
        if (tx_bits == TX_LAST) tx_busy <= 1'b0;
      end else begin
        tx_cnt <= tx_cnt + CNT_ONE;
      end
    end
  end

endmodule
